// File: rtl/healthcare_pkg.sv
// Shared types and widths for the healthcare analysis path.
// Used by the alarm manager and the analysis core.
package healthcare_pkg;

  localparam int WARN_W = 3;
  localparam int VEC_W  = 6;

  typedef enum logic [1:0] {
    IDLE,
    ALERT,
    ESCALATE,
    HOLD
  } alarm_state_t;

  typedef enum logic [1:0] {
    BZ_OFF,
    BZ_TOGGLE,
    BZ_STEADY
  } buzz_mode_t;

  function automatic logic [WARN_W-1:0] warn_max(
    input logic [WARN_W-1:0] a,
    input logic [WARN_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/healthcare_alarm_manager_if.sv
// Abnormality report in, alarm indicators out.
// master drives reports/confirm, slave is the alarm manager.
interface healthcare_alarm_manager_if
  import healthcare_pkg::*;
();

  logic              vectorValid;
  logic [WARN_W-1:0] abnormalityWarning;
  logic [VEC_W-1:0]  abnormalityVector;
  logic              confirm;
  logic              alarmActive;
  logic              escalated;
  logic [VEC_W-1:0]  latchedVector;
  logic [WARN_W-1:0] latchedWarning;
  logic              buzzer;
  logic [7:0]        eventCount;

  modport master (
    output vectorValid,
    output abnormalityWarning,
    output abnormalityVector,
    output confirm,
    input  alarmActive,
    input  escalated,
    input  latchedVector,
    input  latchedWarning,
    input  buzzer,
    input  eventCount
  );

  modport slave (
    input  vectorValid,
    input  abnormalityWarning,
    input  abnormalityVector,
    input  confirm,
    output alarmActive,
    output escalated,
    output latchedVector,
    output latchedWarning,
    output buzzer,
    output eventCount
  );

endinterface

// File: rtl/alarm_buzzer_gen.sv
// Buzzer drive: off, steady, or a BUZZ_DIV half-period toggle.
// The toggle restarts high whenever toggle mode is newly entered.
module alarm_buzzer_gen
  import healthcare_pkg::*;
#(
  parameter int BUZZ_DIV = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  buzz_mode_t mode,
  output logic       buzzer
);

  localparam int DW = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
  localparam logic [DW-1:0] DLAST = DW'(BUZZ_DIV - 1);

  logic [DW-1:0] r_div;
  buzz_mode_t    r_prev;
  logic          r_buzz;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div  <= '0;
      r_prev <= BZ_OFF;
      r_buzz <= 1'b0;
    end else begin
      r_prev <= mode;
      unique case (mode)
        BZ_TOGGLE: begin
          if (r_prev != BZ_TOGGLE) begin
            r_buzz <= 1'b1;
            r_div  <= '0;
          end else if (r_div == DLAST) begin
            r_buzz <= ~r_buzz;
            r_div  <= '0;
          end else begin
            r_div  <= r_div + 1'b1;
          end
        end
        BZ_STEADY: begin
          r_buzz <= 1'b1;
          r_div  <= '0;
        end
        default: begin
          r_buzz <= 1'b0;
          r_div  <= '0;
        end
      endcase
    end
  end

  assign buzzer = r_buzz;

endmodule

// File: rtl/healthcare_alarm_manager.sv
// Latched, acknowledgeable alarm with timed escalation,
// buzzer drive and a saturating alarm-entry counter.
module healthcare_alarm_manager
  import healthcare_pkg::*;
#(
  parameter int ESCALATE_CYCLES = 16,
  parameter int BUZZ_DIV        = 4
) (
  input logic                       clock,
  input logic                       reset,
  healthcare_alarm_manager_if.slave bus
);

  localparam int TW = $clog2(ESCALATE_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(ESCALATE_CYCLES - 1);

  alarm_state_t      r_state;
  logic [VEC_W-1:0]  r_vec;
  logic [WARN_W-1:0] r_warn;
  logic [TW-1:0]     r_timer;
  logic [7:0]        r_cnt;
  logic              r_active;
  logic              r_esc;

  alarm_state_t      w_next;
  logic [VEC_W-1:0]  w_vec;
  logic [WARN_W-1:0] w_warn;
  logic [TW-1:0]     w_timer;
  logic              w_entry;
  logic              w_abn;
  logic              w_new;
  buzz_mode_t        w_mode;
  logic [VEC_W-1:0]  w_mvec;
  logic [WARN_W-1:0] w_mwarn;

  assign w_abn = bus.vectorValid && (|bus.abnormalityVector);
  assign w_new = bus.vectorValid
              && (|(bus.abnormalityVector & ~r_vec));
  assign w_mvec  = r_vec | bus.abnormalityVector;
  assign w_mwarn = warn_max(r_warn, bus.abnormalityWarning);

  always_comb begin
    w_next  = r_state;
    w_vec   = r_vec;
    w_warn  = r_warn;
    w_entry = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_abn) begin
          w_next  = ALERT;
          w_vec   = bus.abnormalityVector;
          w_warn  = bus.abnormalityWarning;
          w_entry = 1'b1;
        end
      end
      ALERT: begin
        if (w_abn) begin
          w_vec  = w_mvec;
          w_warn = w_mwarn;
        end
        if (bus.confirm)
          w_next = HOLD;
        else if (r_timer == TLAST)
          w_next = ESCALATE;
      end
      ESCALATE: begin
        if (w_abn) begin
          w_vec  = w_mvec;
          w_warn = w_mwarn;
        end
        if (bus.confirm)
          w_next = HOLD;
      end
      HOLD: begin
        if (bus.vectorValid) begin
          if (!w_abn) begin
            w_next = IDLE;
            w_vec  = '0;
            w_warn = '0;
          end else if (w_new) begin
            w_next  = ALERT;
            w_vec   = w_mvec;
            w_warn  = w_mwarn;
            w_entry = 1'b1;
          end else begin
            w_warn = w_mwarn;
          end
        end
      end
    endcase

    // timer only runs while staying in ALERT
    if (w_next == ALERT && !w_entry)
      w_timer = r_timer + 1'b1;
    else
      w_timer = '0;

    unique case (w_next)
      ALERT:    w_mode = BZ_TOGGLE;
      ESCALATE: w_mode = BZ_STEADY;
      default:  w_mode = BZ_OFF;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_vec    <= '0;
      r_warn   <= '0;
      r_timer  <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_esc    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_vec    <= w_vec;
      r_warn   <= w_warn;
      r_timer  <= w_timer;
      r_active <= (w_next == ALERT) || (w_next == ESCALATE);
      r_esc    <= (w_next == ESCALATE);
      if (w_entry && r_cnt != 8'hFF)
        r_cnt <= r_cnt + 8'd1;
    end
  end

  alarm_buzzer_gen #(
    .BUZZ_DIV (BUZZ_DIV)
  ) u_buzz (
    .clock  (clock),
    .reset  (reset),
    .mode   (w_mode),
    .buzzer (bus.buzzer)
  );

  assign bus.alarmActive    = r_active;
  assign bus.escalated      = r_esc;
  assign bus.latchedVector  = r_vec;
  assign bus.latchedWarning = r_warn;
  assign bus.eventCount     = r_cnt;

endmodule

// File: tb/tb_healthcare_alarm_manager.sv
// Directed bench for healthcare_alarm_manager.
// Expected values are hand-derived per step.
module tb_healthcare_alarm_manager;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   exp_cnt;

  healthcare_alarm_manager_if bus();

  healthcare_alarm_manager #(
    .ESCALATE_CYCLES (16),
    .BUZZ_DIV        (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic strobe(
    input logic [5:0] v,
    input logic [2:0] w,
    input logic       c
  );
    bus.vectorValid        = 1'b1;
    bus.abnormalityVector  = v;
    bus.abnormalityWarning = w;
    bus.confirm            = c;
    tick(1);
    bus.vectorValid        = 1'b0;
    bus.abnormalityVector  = '0;
    bus.abnormalityWarning = '0;
    bus.confirm            = 1'b0;
  endtask

  task automatic ack();
    bus.confirm = 1'b1;
    tick(1);
    bus.confirm = 1'b0;
  endtask

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_act"}, {7'd0, bus.alarmActive}, 8'd0);
    chk({tag, "_esc"}, {7'd0, bus.escalated}, 8'd0);
    chk({tag, "_vec"}, {2'd0, bus.latchedVector}, 8'd0);
    chk({tag, "_warn"}, {5'd0, bus.latchedWarning}, 8'd0);
    chk({tag, "_buz"}, {7'd0, bus.buzzer}, 8'd0);
    chk({tag, "_cnt"}, bus.eventCount, 8'd0);
  endtask

  initial begin
    bus.vectorValid        = 1'b0;
    bus.abnormalityVector  = '0;
    bus.abnormalityWarning = '0;
    bus.confirm            = 1'b0;
    tick(3);
    chk_all_zero("reset");
    reset = 1'b0;
    tick(1);

    // basic entry
    strobe(6'b000101, 3'd2, 1'b0);
    chk("entry_act", {7'd0, bus.alarmActive}, 8'd1);
    chk("entry_vec", {2'd0, bus.latchedVector}, 8'h05);
    chk("entry_warn", {5'd0, bus.latchedWarning}, 8'd2);
    chk("entry_cnt", bus.eventCount, 8'd1);
    chk("entry_buz", {7'd0, bus.buzzer}, 8'd1);
    chk("entry_esc", {7'd0, bus.escalated}, 8'd0);
    tick(3);
    chk("buz_k3", {7'd0, bus.buzzer}, 8'd1);
    tick(1);
    chk("buz_k4", {7'd0, bus.buzzer}, 8'd0);

    // merge with lower warning
    strobe(6'b100000, 3'd1, 1'b0);
    chk("merge_vec", {2'd0, bus.latchedVector}, 8'h25);
    chk("merge_warn", {5'd0, bus.latchedWarning}, 8'd2);
    tick(3);
    chk("buz_k8", {7'd0, bus.buzzer}, 8'd1);
    tick(7);
    chk("k15_esc", {7'd0, bus.escalated}, 8'd0);
    chk("k15_act", {7'd0, bus.alarmActive}, 8'd1);

    // confirm on the expiry cycle wins
    ack();
    chk("tie_esc", {7'd0, bus.escalated}, 8'd0);
    chk("tie_act", {7'd0, bus.alarmActive}, 8'd0);
    chk("tie_buz", {7'd0, bus.buzzer}, 8'd0);
    tick(2);
    chk("hold_esc", {7'd0, bus.escalated}, 8'd0);

    // HOLD: subset stays, warning maxes
    strobe(6'b000100, 3'd3, 1'b0);
    chk("sub_act", {7'd0, bus.alarmActive}, 8'd0);
    chk("sub_cnt", bus.eventCount, 8'd1);
    chk("sub_warn", {5'd0, bus.latchedWarning}, 8'd3);
    chk("sub_vec", {2'd0, bus.latchedVector}, 8'h25);

    // HOLD: new bit re-arms
    strobe(6'b010000, 3'd0, 1'b0);
    chk("rearm_act", {7'd0, bus.alarmActive}, 8'd1);
    chk("rearm_vec", {2'd0, bus.latchedVector}, 8'h35);
    chk("rearm_cnt", bus.eventCount, 8'd2);
    chk("rearm_buz", {7'd0, bus.buzzer}, 8'd1);

    // escalation 16 cycles after entry
    tick(15);
    chk("esc_k15", {7'd0, bus.escalated}, 8'd0);
    tick(1);
    chk("esc_k16", {7'd0, bus.escalated}, 8'd1);
    chk("esc_act", {7'd0, bus.alarmActive}, 8'd1);
    tick(5);
    chk("esc_buz", {7'd0, bus.buzzer}, 8'd1);
    chk("esc_hold", {7'd0, bus.escalated}, 8'd1);
    strobe(6'b000010, 3'd5, 1'b0);
    chk("esc_mvec", {2'd0, bus.latchedVector}, 8'h37);
    chk("esc_mwarn", {5'd0, bus.latchedWarning}, 8'd5);
    ack();
    chk("escack_act", {7'd0, bus.alarmActive}, 8'd0);
    chk("escack_esc", {7'd0, bus.escalated}, 8'd0);
    chk("escack_buz", {7'd0, bus.buzzer}, 8'd0);
    chk("escack_vec", {2'd0, bus.latchedVector}, 8'h37);

    // clear to IDLE
    strobe(6'b000000, 3'd4, 1'b0);
    chk("clr_vec", {2'd0, bus.latchedVector}, 8'h00);
    chk("clr_warn", {5'd0, bus.latchedWarning}, 8'd0);
    chk("clr_cnt", bus.eventCount, 8'd2);
    ack();
    chk("idle_conf", {7'd0, bus.alarmActive}, 8'd0);

    // IDLE ignores confirm; merge then HOLD in ALERT
    strobe(6'b000001, 3'd1, 1'b1);
    chk("idlec_act", {7'd0, bus.alarmActive}, 8'd1);
    chk("idlec_cnt", bus.eventCount, 8'd3);
    strobe(6'b001000, 3'd6, 1'b1);
    chk("mc_act", {7'd0, bus.alarmActive}, 8'd0);
    chk("mc_vec", {2'd0, bus.latchedVector}, 8'h09);
    chk("mc_warn", {5'd0, bus.latchedWarning}, 8'd6);
    strobe(6'b000000, 3'd0, 1'b0);
    chk("mc_clr", {2'd0, bus.latchedVector}, 8'h00);

    // saturation
    exp_cnt = 3;
    for (int i = 0; i < 260; i++) begin
      strobe(6'b000001, 3'd0, 1'b0);
      ack();
      strobe(6'b000000, 3'd0, 1'b0);
      if (exp_cnt < 255) exp_cnt++;
      chk("sat", bus.eventCount, 8'(exp_cnt));
    end
    chk("sat_end", bus.eventCount, 8'd255);

    // async reset while escalated
    strobe(6'b110000, 3'd7, 1'b0);
    tick(16);
    chk("pre_rst_esc", {7'd0, bus.escalated}, 8'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("async");
    tick(1);
    #2;
    reset = 1'b0;
    tick(1);
    chk("post_act", {7'd0, bus.alarmActive}, 8'd0);
    strobe(6'b000010, 3'd1, 1'b0);
    chk("post_cnt", bus.eventCount, 8'd1);
    chk("post_act2", {7'd0, bus.alarmActive}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
